// File: rtl/clkmode_seq_pkg.sv
// Shared types for the clock-mode sequencer: state encoding, cfg bit positions, helpers.
// The WARM state is only present when CLKSEQ_WARMUP_EN is defined.
package p1v_clk_pkg;

  localparam int CFG_RESET     = 7;
  localparam int CFG_PLLENA    = 6;
  localparam int CFG_OSCENA    = 5;
  localparam int CFG_OSCM_HI   = 4;
  localparam int CFG_OSCM_LO   = 3;
  localparam int CFG_CLKSEL_HI = 2;
  localparam int CFG_CLKSEL_LO = 0;
  localparam int CNT_W         = 24;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_IDLE   = 3'd1,
`ifdef CLKSEQ_WARMUP_EN
    ST_WARM   = 3'd2,
`endif
    ST_SWITCH = 3'd3,
    ST_GUARD  = 3'd4,
    ST_RST    = 3'd5
  } clkseq_state_e;

  // A state lasting n cycles is entered with the counter at n-1.
  function automatic logic [CNT_W-1:0] cycles_to_load(input int n);
    return CNT_W'(n - 1);
  endfunction

  // Warm-up is needed only when an oscillator or PLL enable goes from 0 to 1.
  function automatic logic warm_needed(input logic [7:0] cur, input logic [7:0] req);
    return (req[CFG_PLLENA] & ~cur[CFG_PLLENA]) | (req[CFG_OSCENA] & ~cur[CFG_OSCENA]);
  endfunction

endpackage

// File: rtl/clkseq_timer.sv
// Single down-counter shared by all timed states; parks at zero between loads.
module clkseq_timer
  import p1v_clk_pkg::*;
(
  input  logic             clk_cog,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count_r;

  // Reload on state entry, otherwise count down and hold at zero.
  always_ff @(posedge clk_cog) begin
    if (load) begin
      count_r <= value;
    end else if (count_r != {CNT_W{1'b0}}) begin
      count_r <= count_r - CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/clkmode_seq.sv
// Clock-mode sequencer: applies clock generator modes with warm-up, settle and core reset timing.
// Optional warm-up wait is built in when CLKSEQ_WARMUP_EN is defined.
module clkmode_seq
  import p1v_clk_pkg::*;
#(
  parameter int WARM_CYCLES  = 800000,
  parameter int GUARD_CYCLES = 16,
  parameter int RESET_CYCLES = 64
) (
  input  logic       clk_cog,
  input  logic       res,
  input  logic       req_valid,
  input  logic [7:0] req_cfg,
  output logic       req_ready,
  output logic [7:0] cfg,
  output logic       nres,
  output logic       busy
);

  localparam logic [CNT_W-1:0] RESET_LOAD  = cycles_to_load(RESET_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LOAD  = cycles_to_load(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] SWITCH_LOAD = cycles_to_load(1);
`ifdef CLKSEQ_WARMUP_EN
  localparam logic [CNT_W-1:0] WARM_LOAD   = cycles_to_load(WARM_CYCLES);
`else
  logic [CNT_W-1:0] warm_unused_s;
  assign warm_unused_s = cycles_to_load(WARM_CYCLES);
`endif

  clkseq_state_e    state_r, state_next_s;
  logic [7:0]       cfg_r, cfg_next_s;
  logic [6:0]       req_lat_r, req_lat_next_s;
  logic             req_ready_r, nres_r, busy_r;
  logic             timer_load_s, timer_done_s;
  logic [CNT_W-1:0] timer_val_s;

  // Reset overrides the FSM's own load so BOOT always starts with a full count.
  clkseq_timer u_timer (
    .clk_cog (clk_cog),
    .load    (timer_load_s | res),
    .value   (res ? RESET_LOAD : timer_val_s),
    .done    (timer_done_s)
  );

  // Next-state, next-cfg and timer load selection.
  always_comb begin
    state_next_s   = state_r;
    cfg_next_s     = cfg_r;
    req_lat_next_s = req_lat_r;
    timer_load_s   = 1'b0;
    timer_val_s    = {CNT_W{1'b0}};
    case (state_r)
      ST_BOOT, ST_RST: begin
        if (timer_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_IDLE: begin
        if (req_valid && req_cfg[CFG_RESET]) begin
          state_next_s = ST_RST;
          cfg_next_s   = 8'h00;
          timer_load_s = 1'b1;
          timer_val_s  = RESET_LOAD;
        end
`ifdef CLKSEQ_WARMUP_EN
        else if (req_valid && warm_needed(cfg_r, req_cfg)) begin
          state_next_s   = ST_WARM;
          cfg_next_s[CFG_PLLENA:CFG_OSCM_LO] = req_cfg[CFG_PLLENA:CFG_OSCM_LO];
          req_lat_next_s = req_cfg[CFG_PLLENA:CFG_CLKSEL_LO];
          timer_load_s   = 1'b1;
          timer_val_s    = WARM_LOAD;
        end
`endif
        else if (req_valid) begin
          state_next_s   = ST_SWITCH;
          req_lat_next_s = req_cfg[CFG_PLLENA:CFG_CLKSEL_LO];
          timer_load_s   = 1'b1;
          timer_val_s    = SWITCH_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
`ifdef CLKSEQ_WARMUP_EN
      ST_WARM: begin
        if (timer_done_s) begin
          state_next_s = ST_SWITCH;
          timer_load_s = 1'b1;
          timer_val_s  = SWITCH_LOAD;
        end else begin
          state_next_s = ST_WARM;
        end
      end
`endif
      ST_SWITCH: begin
        state_next_s = ST_GUARD;
        cfg_next_s   = {1'b0, req_lat_r};
        timer_load_s = 1'b1;
        timer_val_s  = GUARD_LOAD;
      end
      ST_GUARD: begin
        if (timer_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_GUARD;
        end
      end
      default: begin
        state_next_s = ST_BOOT;
        cfg_next_s   = 8'h00;
        timer_load_s = 1'b1;
        timer_val_s  = RESET_LOAD;
      end
    endcase
  end

  // State, applied cfg and outputs, all registered from the next state.
  always_ff @(posedge clk_cog) begin
    if (res) begin
      state_r     <= ST_BOOT;
      cfg_r       <= 8'h00;
      req_lat_r   <= 7'h00;
      req_ready_r <= 1'b0;
      nres_r      <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      cfg_r       <= cfg_next_s;
      req_lat_r   <= req_lat_next_s;
      req_ready_r <= (state_next_s == ST_IDLE);
      nres_r      <= (state_next_s != ST_BOOT) && (state_next_s != ST_RST);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  assign req_ready = req_ready_r;
  assign cfg       = cfg_r;
  assign nres      = nres_r;
  assign busy      = busy_r;

endmodule

// File: doc/clkmode_seq.md
CLKMODE_SEQ -- requirements
Module: clkmode_seq

Interface
REQ-001 SHALL have parameter WARM_CYCLES, default 800000, oscillator/PLL warm-up wait in clk_cog cycles (range 1..2^24-1).
REQ-002 SHALL have parameter GUARD_CYCLES, default 16, settle cycles after a clock select change (range 1..255).
REQ-003 SHALL have parameter RESET_CYCLES, default 64, core reset pulse length in cycles (range 1..255).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk_cog  in  1  sole clock; all state changes on its rising edge.
REQ-006 res  in  1  synchronous active-high reset.
REQ-007 req_valid  in  1  clock mode write request.
REQ-008 req_cfg  in  8  requested mode: [7] RESET, [6] PLLENA, [5] OSCENA, [4:3] OSCM, [2:0] CLKSEL.
REQ-009 req_ready  out  1  request is accepted on the edge where req_valid & req_ready.
REQ-010 cfg  out  8  applied clock mode to the clock generator; bit 7 is always 0.
REQ-011 nres  out  1  active-low core reset.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 States: BOOT, IDLE, WARM, SWITCH, GUARD, RST.
REQ-014 BOOT: nres=0 for RESET_CYCLES cycles, then IDLE.
REQ-015 IDLE: req_ready=1, nres=1; all other states: req_ready=0.
REQ-016 Accept with req_cfg[7]=1: go to RST; cfg<=8'h00 on the next edge; nres=0 for RESET_CYCLES cycles; then IDLE; bits [6:0] of that request are discarded.
REQ-017 Accept with req_cfg[7]=0 that sets PLLENA or OSCENA currently 0 in cfg: go to WARM; on WARM entry cfg[6:3]<=req_cfg[6:3], cfg[2:0] held; stay exactly WARM_CYCLES cycles; then SWITCH.
REQ-018 Any other accept with req_cfg[7]=0 goes directly to SWITCH, including requests that only clear enables.
REQ-019 SWITCH: one cycle; cfg<={1'b0,req_cfg[6:0]}; then GUARD.
REQ-020 GUARD: exactly GUARD_CYCLES cycles, then IDLE.
REQ-021 No-warm latency: cfg updates on the edge after the accept edge; req_ready reasserts GUARD_CYCLES+1 cycles later.
REQ-022 The request is latched at accept; later req_cfg changes have no effect until the next accept.
REQ-023 req_valid in non-IDLE states is ignored; the requester holds it until ready.
REQ-024 A request equal to current cfg still runs SWITCH+GUARD.
REQ-025 A single 24-bit down-counter is loaded with N-1 on state entry; the state exits on the edge where the count is 0.

Reset
REQ-026 When res=1: state<=BOOT, cfg<=8'h00, nres<=0, req_ready<=0, busy<=1, counter loaded for RESET_CYCLES, latched request cleared.
REQ-027 res asserted in any state, including mid-WARM or mid-RST, aborts the operation with no partial cfg write afterwards.

Configuration
REQ-028 With CLKSEQ_WARMUP_EN defined: WARM state and REQ-017 are present.
REQ-029 Without CLKSEQ_WARMUP_EN: WARM is removed; every non-reset request goes directly to SWITCH; WARM_CYCLES is unused.

Structure
REQ-030 Package p1v_clk_pkg SHALL hold the state enum and cfg bit-index constants (CFG_RESET=7, CFG_PLLENA=6, CFG_OSCENA=5, CFG_OSCM=4:3, CFG_CLKSEL=2:0).
REQ-031 The down-counter SHALL be sub-module clkseq_timer: load, value, done.

Verification (WARM_CYCLES=10, GUARD_CYCLES=4, RESET_CYCLES=8)
REQ-032 Release res -> nres=0 for 8 cycles, then nres=1, req_ready=1, cfg=8'h00.
REQ-033 From cfg=00, accept 8'h6F -> next edge cfg=8'h68; 10 cycles WARM; then cfg=8'h6F; req_ready returns 4 cycles later.
REQ-034 From cfg=6F, accept 8'h00 -> cfg=8'h00 on the next edge, with no WARM; ready after 5 cycles.
REQ-035 Accept 8'h80 from cfg=6F -> cfg=00, nres low 8 cycles, then IDLE.
REQ-036 res pulse at WARM cycle 5 -> BOOT, cfg=00, and cfg never becomes 6F.
REQ-037 req_valid toggled during GUARD -> no accept until IDLE; macro undefined: 8'h6F -> cfg=6F on the next edge, no WARM.
